// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Master game sequencer.
//
//               The block has three screens: START, GAME and END. It drives
//               the screen enables, a one-second tick, the BCD score and the
//               seconds remaining. These signals feed the start, game and
//               end-screen overlays.
//
// Ports       : clk, rst        - pixel clock, synchronous active-high reset
//               space_pulse     - one-cycle pulse per spacebar press
//               jump_ok         - one-cycle pulse, landed on a platform
//               jump_fail_in    - one-cycle pulse, missed a platform
//               start_en        - start screen enable
//               game_en         - game screen enable
//               end_en          - end screen enable
//               jump_fail       - end reason (1 = fall, 0 = timeout)
//               one_sec_tick    - one-cycle pulse every CLK_HZ cycles
//               score[11:0]     - 3-digit BCD score, [11:8] = hundreds
//               time_left[6:0]  - seconds remaining, binary
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
    parameter int CLK_HZ      = 65_000_000,
    parameter int GAME_TIME_S = 60,
    parameter int END_LOCK_S  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        space_pulse,
    input  logic        jump_ok,
    input  logic        jump_fail_in,
    output logic        start_en,
    output logic        game_en,
    output logic        end_en,
    output logic        jump_fail,
    output logic        one_sec_tick,
    output logic [11:0] score,
    output logic [6:0]  time_left
);

    localparam int              c_PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_HZ - 1);
    localparam logic [6:0]      c_GAME_TIME = 7'(GAME_TIME_S);
    localparam logic [3:0]      c_END_LOCK  = 4'(END_LOCK_S);

    localparam logic [1:0] c_ST_START = 2'd0;
    localparam logic [1:0] c_ST_GAME  = 2'd1;
    localparam logic [1:0] c_ST_END   = 2'd2;

    logic [1:0]      r_state_q,    w_state_d;
    logic [c_PW-1:0] r_presc_q,    w_presc_d;
    logic            r_tick_q,     w_tick_d;
    logic [3:0]      r_lock_q,     w_lock_d;
    logic [11:0]     r_score_q,    w_score_d;
    logic [6:0]      r_time_q,     w_time_d;
    logic            r_jf_q,       w_jf_d;
    logic            r_start_en_q, w_start_en_d;
    logic            r_game_en_q,  w_game_en_d;
    logic            r_end_en_q,   w_end_en_d;
    logic            w_trans;

    // Add one to the BCD score with a carry between digits. The score
    // stops at 999.
    function automatic logic [11:0] f_bcd_inc(input logic [11:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v != 12'h999) begin
            if (d0 != 4'd9) begin
                d0 = d0 + 4'd1;
            end else begin
                d0 = 4'd0;
                if (d1 != 4'd9) begin
                    d1 = d1 + 4'd1;
                end else begin
                    d1 = 4'd0;
                    d2 = d2 + 4'd1;
                end
            end
        end
        return {d2, d1, d0};
    endfunction

    always_comb begin
        w_state_d = r_state_q;
        w_score_d = r_score_q;
        w_time_d  = r_time_q;
        w_jf_d    = r_jf_q;
        w_lock_d  = r_lock_q;

        case (r_state_q)
            c_ST_START: begin
                if (space_pulse) begin
                    w_state_d = c_ST_GAME;
                    w_score_d = 12'h000;
                    w_time_d  = c_GAME_TIME;
                end
            end
            c_ST_GAME: begin
                // A fall in the same cycle as a landing takes priority,
                // so the score does not count that landing.
                if (jump_ok && !jump_fail_in) begin
                    w_score_d = f_bcd_inc(r_score_q);
                end
                if (r_tick_q) begin
                    w_time_d = r_time_q - 7'd1;
                end
                if (jump_fail_in) begin
                    w_state_d = c_ST_END;
                    w_jf_d    = 1'b1;
                end else if (r_tick_q && (r_time_q == 7'd1)) begin
                    w_state_d = c_ST_END;
                    w_jf_d    = 1'b0;
                end
            end
            c_ST_END: begin
                if (r_tick_q && (r_lock_q < c_END_LOCK)) begin
                    w_lock_d = r_lock_q + 4'd1;
                end
                // The space test uses the lock count from before this
                // cycle's increment.
                if (space_pulse && (r_lock_q == c_END_LOCK)) begin
                    w_state_d = c_ST_START;
                end
            end
            default: begin
                w_state_d = c_ST_START;
            end
        endcase

        w_trans = (w_state_d != r_state_q);

        // Every screen change restarts the second count from zero. A tick
        // that would line up with the screen change is dropped, so each
        // screen sees a full second before its first tick.
        if (w_trans || (r_presc_q == c_PRESC_MAX)) begin
            w_presc_d = '0;
        end else begin
            w_presc_d = r_presc_q + c_PW'(1);
        end
        w_tick_d = (r_presc_q == c_PRESC_MAX) && !w_trans;

        if (w_trans) begin
            w_lock_d = 4'd0;
        end

        w_start_en_d = (w_state_d == c_ST_START);
        w_game_en_d  = (w_state_d == c_ST_GAME);
        w_end_en_d   = (w_state_d == c_ST_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_START;
            r_presc_q    <= '0;
            r_tick_q     <= 1'b0;
            r_lock_q     <= 4'd0;
            r_score_q    <= 12'h000;
            r_time_q     <= c_GAME_TIME;
            r_jf_q       <= 1'b0;
            r_start_en_q <= 1'b1;
            r_game_en_q  <= 1'b0;
            r_end_en_q   <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_presc_q    <= w_presc_d;
            r_tick_q     <= w_tick_d;
            r_lock_q     <= w_lock_d;
            r_score_q    <= w_score_d;
            r_time_q     <= w_time_d;
            r_jf_q       <= w_jf_d;
            r_start_en_q <= w_start_en_d;
            r_game_en_q  <= w_game_en_d;
            r_end_en_q   <= w_end_en_d;
        end
    end

    assign start_en     = r_start_en_q;
    assign game_en      = r_game_en_q;
    assign end_en       = r_end_en_q;
    assign jump_fail    = r_jf_q;
    assign one_sec_tick = r_tick_q;
    assign score        = r_score_q;
    assign time_left    = r_time_q;

endmodule
`default_nettype wire
